// File: rtl/game_seq_ctrl_pkg.sv
// Shared constants for the game sequencer: state encodings and the default death-freeze length.
// Pure declarations; no logic, no latency.
package game_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int DEATH_FRAMES_DEF = 60;
  localparam int SCORE_DIGITS_DEF = 4;
  localparam int TIMER_W_DEF      = 8;
  localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/game_seq_ctrl_bcd_counter.sv
// Multi-digit BCD incrementer with synchronous clear, enable and saturation at all nines.
// 1-cycle latency; count_nxt exposes the value the register takes at the next edge.
module bcd_counter
  import game_seq_ctrl_pkg::*;
#(
  parameter int DIGITS = SCORE_DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   count_nxt
);

  logic all_nines;
  logic carry;

  always_comb begin
    all_nines = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (count[d*4 +: 4] != BCD_NINE) all_nines = 1'b0;
    end
  end

  // Ripple the carry from the LSD; a saturated counter never starts a carry.
  always_comb begin
    count_nxt = count;
    carry     = en & ~all_nines;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (count[d*4 +: 4] == BCD_NINE) begin
          count_nxt[d*4 +: 4] = 4'd0;
        end else begin
          count_nxt[d*4 +: 4] = count[d*4 +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    if (clr) count_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_nxt;
  end

endmodule

// File: rtl/game_seq_ctrl.sv
// Game sequencer: start/play/death-freeze/over flow, column gating, BCD score; all outputs registered (1 cycle).
// Optional high-score tracking under GAME_SEQ_HISCORE_EN; no backpressure, inputs are single-cycle pulses/levels.
module game_seq_ctrl
  import game_seq_ctrl_pkg::*;
#(
  parameter int SCORE_DIGITS = SCORE_DIGITS_DEF,
  parameter int DEATH_FRAMES = DEATH_FRAMES_DEF,
  parameter int TIMER_W      = TIMER_W_DEF
) (
  input  logic                      gameClk,
  input  logic                      reset,
  input  logic                      frameTick,
  input  logic                      flap,
  input  logic                      collision,
  input  logic                      passColumn,
  output logic                      colReset,
  output logic                      colStep,
  output logic [1:0]                state,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic                      finished
`ifdef GAME_SEQ_HISCORE_EN
  ,
  output logic [4*SCORE_DIGITS-1:0] hiScore,
  output logic                      newRecord
`endif
);

  state_t               state_q;
  state_t               state_d;
  logic                 pass_q;
  logic                 pass_rise;
  logic [TIMER_W-1:0]   timer_q;
  logic                 timer_done;
  logic                 col_reset_d;
  logic                 col_step_d;
  logic                 finished_d;
  logic                 score_clr;
  logic                 score_inc;
  logic [4*SCORE_DIGITS-1:0] score_nxt;

  // passColumn may be held for several cycles; only its rising edge scores.
  assign pass_rise  = passColumn & ~pass_q;
  assign timer_done = (state_q == ST_DYING) && frameTick &&
                      (timer_q == TIMER_W'(DEATH_FRAMES - 1));
  assign score_clr  = (state_q == ST_IDLE) && flap;
  assign score_inc  = (state_q == ST_PLAY) && pass_rise;

  // State and registered-output register.
  always_ff @(posedge gameClk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      colReset <= 1'b1;
      colStep  <= 1'b0;
      finished <= 1'b0;
    end else begin
      state_q  <= state_d;
      colReset <= col_reset_d;
      colStep  <= col_step_d;
      finished <= finished_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (flap)       state_d = ST_PLAY;
      ST_PLAY:  if (collision)  state_d = ST_DYING;
      ST_DYING: if (timer_done) state_d = ST_OVER;
      ST_OVER:  if (flap)       state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decided from the state being entered so they line up with it.
  always_comb begin
    col_reset_d = (state_d == ST_IDLE);
    col_step_d  = (state_q == ST_PLAY) && (state_d == ST_PLAY) && frameTick;
    finished_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge gameClk or negedge reset) begin
    if (!reset) begin
      pass_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      pass_q <= passColumn;
      if (state_q != ST_DYING || timer_done) timer_q <= '0;
      else if (frameTick)                    timer_q <= timer_q + 1'b1;
    end
  end

  assign state = state_q;

  bcd_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .clk       (gameClk),
    .rst_n     (reset),
    .clr       (score_clr),
    .en        (score_inc),
    .count     (score),
    .count_nxt (score_nxt)
  );

`ifdef GAME_SEQ_HISCORE_EN
  logic die_now;
  logic score_gt;
  logic decided;

  assign die_now = (state_q == ST_PLAY) && collision;

  // Digit-wise compare from the MSD down; the first differing digit decides.
  always_comb begin
    score_gt = 1'b0;
    decided  = 1'b0;
    for (int d = SCORE_DIGITS - 1; d >= 0; d--) begin
      if (!decided && (score_nxt[d*4 +: 4] != hiScore[d*4 +: 4])) begin
        score_gt = (score_nxt[d*4 +: 4] > hiScore[d*4 +: 4]);
        decided  = 1'b1;
      end
    end
  end

  always_ff @(posedge gameClk or negedge reset) begin
    if (!reset) begin
      hiScore   <= '0;
      newRecord <= 1'b0;
    end else if (die_now) begin
      if (score_gt) hiScore <= score_nxt;
      newRecord <= score_gt;
    end else if (score_clr) begin
      newRecord <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/game_seq_ctrl.md
Name: game_seq_ctrl

Overview:
- Top-level game sequencer for the Flappy-style game.
- Holds the column generator in reset until the player starts, and gates column motion to one step per frame during play.
- Counts passed columns into a BCD score, runs a death-freeze timer after collision, and raises `finished` for the display/end screen.
- Sits between the input debouncers/collision checker and the column generator/score display.

Parameters:
- SCORE_DIGITS, 4: BCD digits in the score; score width = 4*SCORE_DIGITS.
- DEATH_FRAMES, 60: frameTick pulses spent in DYING before OVER (1..255).
- TIMER_W, 8: width of the death-frame counter.

Ports:
- gameClk  in  1  game clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- frameTick  in  1  one-cycle pulse per video frame.
- flap  in  1  debounced one-cycle button pulse.
- collision  in  1  level from the collision checker; 1 = bird overlaps a pipe or the screen edge.
- passColumn  in  1  pulse from the column generator when a column wraps.
- colReset  out  1  active-high reset to the column generator.
- colStep  out  1  clock-enable to the column generator; one step per frame.
- state  out  2  0=IDLE, 1=PLAY, 2=DYING, 3=OVER.
- score  out  4*SCORE_DIGITS  BCD score, digit 0 = LSD.
- finished  out  1  high in OVER.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, colReset=1, colStep=0, score=0, finished=0.
  - Death timer cleared; passColumn edge register cleared.
  - Reset asserted mid-game returns to IDLE immediately; no partial score is retained.
- All outputs are registered: 1-cycle latency from the causing input.
- IDLE:
  - colReset=1, colStep=0.
  - Score holds its last value, so the previous game's result remains visible.
  - flap → PLAY. The same edge clears the score to 0 and drives colReset to 0.
- PLAY:
  - colReset=0; colStep = frameTick delayed one cycle.
  - Score event = passColumn==1 and prev_passColumn==0. This rising-edge detect is required because passColumn may be held high across cycles.
  - Score events outside PLAY are ignored.
  - collision==1 → DYING; colStep forced to 0 from the next cycle.
  - flap is ignored (the bird module consumes it).
- Simultaneous passColumn edge and collision in PLAY: the point is counted and the state goes to DYING.
- DYING:
  - colStep=0, colReset=0, so the columns stay frozen on screen.
  - Timer increments on each frameTick; when timer==DEATH_FRAMES-1 and frameTick==1 → OVER and timer clears.
  - flap and collision are ignored.
- OVER:
  - finished=1, colStep=0.
  - flap → IDLE, finished=0; colReset reasserts next cycle.
- Score arithmetic:
  - BCD ripple increment: a digit of 9 becomes 0 with carry into the next digit.
  - At all 9s (9999 for 4 digits) the score saturates and holds.
- Unreachable state encodings are not possible with a 2-bit state; the default branch goes to IDLE.
- Since a flap in OVER goes to IDLE and needs a further flap to start PLAY, one flap never both restarts and plays.

Optional Feature:
- Macro GAME_SEQ_HISCORE_EN.
- When defined:
  - Extra output hiScore, 4*SCORE_DIGITS bits, BCD; reset value 0 on reset==0.
  - On the PLAY→DYING transition, hiScore ← max(hiScore, score including any simultaneous point).
  - Comparison is by BCD digits from MSD downward.
  - Extra output newRecord, 1 bit: set on that transition if score > hiScore, cleared on the next IDLE→PLAY.
- When undefined: neither port exists and no comparator logic is built.

Decomposition:
- Shared constants file (the existing constants include) gains:
  - state encodings ST_IDLE=0, ST_PLAY=1, ST_DYING=2, ST_OVER=3;
  - DEATH_FRAMES default.
- Existing SCREEN_WIDTH/SCREEN_HEIGHT/PADDING are not needed here.
- One natural sub-module, bcd_counter: parameterized SCORE_DIGITS BCD incrementer with clear, enable and saturation. It is reusable by the display block.

Test Plan:
- Reset low mid-PLAY with score=0012 → immediate state=0, colReset=1, score=0000, colStep=0; release, no flap → stays IDLE indefinitely.
- IDLE, flap pulse → next cycle state=1, colReset=0, score=0000; 5 frameTicks → exactly 5 one-cycle colStep pulses, each 1 cycle after its tick.
- PLAY, passColumn held high 3 cycles, then low, then high 1 cycle → score=0002.
- PLAY, collision in the same cycle as a passColumn edge with score=0009 → score=0010, state=2; no colStep on the following frameTicks; after 60 frameTicks → state=3, finished=1; flap → state=0, score still 0010.
- Score preset to 9998 via events; 3 more passColumn edges → 9999, saturated.
- With GAME_SEQ_HISCORE_EN: game 1 dies at 0007 → hiScore=0007, newRecord=1; game 2 dies at 0003 → hiScore=0007, newRecord=0.
